skinny_inv_sbox8_isw1_pini_ctrl: RTL and testbench

SKINNY_INV_SBOX8_ISW1_PINI_CTRL -- requirements
Module: skinny_inv_sbox8_isw1_pini_ctrl

---
 rtl/skinny_inv_sbox8_isw1_pini_ctrl_pkg.sv | 28 ++
 rtl/skinny_inv_sbox8_isw1_pini_ctrl_gadget.sv | 48 ++++
 rtl/skinny_inv_sbox8_isw1_pini_ctrl.sv | 138 +++++++++++++
 tb/tb_skinny_inv_sbox8_isw1_pini_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/skinny_inv_sbox8_isw1_pini_ctrl_pkg.sv
// rtl/skinny_inv_sbox8_isw1_pini_ctrl_pkg.sv - shared FSM encoding, latency and gadget/mask indices
// Optional feature macro: SKINNY_INV_SBOX_CLR_EN
package skinny_inv_sbox8_isw1_pini_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int         BUSY_CYCLES = 12;
  localparam logic [3:0] BUSY_LAST   = 4'(BUSY_CYCLES - 1);
  localparam int         N_GADGETS   = 8;

  // Gadget index k also selects its mask pair r[2k+1:2k]
  localparam logic [2:0] G_I3 = 3'd0;
  localparam logic [2:0] G_I5 = 3'd1;
  localparam logic [2:0] G_I2 = 3'd2;
  localparam logic [2:0] G_I7 = 3'd3;
  localparam logic [2:0] G_I1 = 3'd4;
  localparam logic [2:0] G_I0 = 3'd5;
  localparam logic [2:0] G_I6 = 3'd6;
  localparam logic [2:0] G_I4 = 3'd7;

  function automatic logic [1:0] share_bit(input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [2:0] b);
    return {x1[b], x0[b]};
  endfunction

endpackage

// File: rtl/skinny_inv_sbox8_isw1_pini_ctrl_gadget.sv
// rtl/skinny_inv_sbox8_isw1_pini_ctrl_gadget.sv - first-order ISW/PINI gadget f = (a nor b) xor z, 3-cycle latency
// Optional feature macro: SKINNY_INV_SBOX_CLR_EN
module isw1_pini_inv_cfn_fr (
`ifdef SKINNY_INV_SBOX_CLR_EN
  input  logic       clr,
`endif
  output logic [1:0] f,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] z,
  input  logic [1:0] r,
  input  logic       clk
);

`ifndef SKINNY_INV_SBOX_CLR_EN
  logic clr;
  assign clr = 1'b0;
`endif

  logic [1:0] a_q, b_q, z_q, z_qq;
  logic       p00, p11, c01, c10;

  // nor(a,b) = ~a & ~b; inversion only touches share 0, b is refreshed by r[0]
  always_ff @(posedge clk) begin
    if (clr) begin
      a_q  <= 2'b00;
      b_q  <= 2'b00;
      z_q  <= 2'b00;
      z_qq <= 2'b00;
      p00  <= 1'b0;
      p11  <= 1'b0;
      c01  <= 1'b0;
      c10  <= 1'b0;
      f    <= 2'b00;
    end else begin
      a_q  <= {a[1], ~a[0]};
      b_q  <= {b[1] ^ r[0], ~b[0] ^ r[0]};
      z_q  <= z;
      p00  <= a_q[0] & b_q[0];
      p11  <= a_q[1] & b_q[1];
      c01  <= (a_q[0] & b_q[1]) ^ r[1];
      c10  <= (a_q[1] & b_q[0]) ^ r[1];
      z_qq <= z_q;
      f    <= {p11 ^ c10 ^ z_qq[1], p00 ^ c01 ^ z_qq[0]};
    end
  end

endmodule

// File: rtl/skinny_inv_sbox8_isw1_pini_ctrl.sv
// rtl/skinny_inv_sbox8_isw1_pini_ctrl.sv - masked SKINNY 8-bit inverse S-box with valid/ready control
// Optional feature macro: SKINNY_INV_SBOX_CLR_EN
module skinny_inv_sbox8_isw1_pini_ctrl
  import skinny_inv_sbox8_isw1_pini_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  si0,
  input  logic [7:0]  si1,
  input  logic [15:0] r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  bo0,
  output logic [7:0]  bo1,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [7:0]  s0_q, s1_q, o0, o1, res0, res1;
  logic [15:0] r_q, m;
  logic        acc, clr;
  logic [1:0]  ga [N_GADGETS];
  logic [1:0]  gb [N_GADGETS];
  logic [1:0]  gz [N_GADGETS];
  logic [1:0]  gf [N_GADGETS];

  assign in_ready  = (state == S_IDLE) & ~rst;
  assign out_valid = (state == S_DONE);
  assign acc       = in_valid & in_ready;

`ifdef SKINNY_INV_SBOX_CLR_EN
  assign clr = rst | (out_valid & out_ready);
`else
  assign clr = 1'b0;
`endif

  // First-layer gadgets sample on the handshake edge, so they see the live inputs then
  assign o0 = acc ? si0 : s0_q;
  assign o1 = acc ? si1 : s1_q;
  assign m  = acc ? r   : r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      s0_q <= 8'h00;
      s1_q <= 8'h00;
      r_q  <= 16'h0000;
    end else if (acc) begin
      s0_q <= si0;
      s1_q <= si1;
      r_q  <= r;
    end
  end

  assign ga[G_I3] = share_bit(o0, o1, 3'd7);
  assign gb[G_I3] = share_bit(o0, o1, 3'd6);
  assign gz[G_I3] = share_bit(o0, o1, 3'd4);
  assign ga[G_I5] = share_bit(o0, o1, 3'd6);
  assign gb[G_I5] = share_bit(o0, o1, 3'd5);
  assign gz[G_I5] = share_bit(o0, o1, 3'd7);
  assign ga[G_I2] = share_bit(o0, o1, 3'd3);
  assign gb[G_I2] = share_bit(o0, o1, 3'd1);
  assign gz[G_I2] = share_bit(o0, o1, 3'd0);
  assign ga[G_I7] = share_bit(o0, o1, 3'd2);
  assign gb[G_I7] = share_bit(o0, o1, 3'd7);
  assign gz[G_I7] = share_bit(o0, o1, 3'd1);
  assign ga[G_I1] = share_bit(o0, o1, 3'd5);
  assign gb[G_I1] = gf[G_I3];
  assign gz[G_I1] = share_bit(o0, o1, 3'd3);
  assign ga[G_I0] = gf[G_I3];
  assign gb[G_I0] = gf[G_I2];
  assign gz[G_I0] = share_bit(o0, o1, 3'd5);
  assign ga[G_I6] = gf[G_I2];
  assign gb[G_I6] = gf[G_I1];
  assign gz[G_I6] = share_bit(o0, o1, 3'd2);
  assign ga[G_I4] = gf[G_I7];
  assign gb[G_I4] = gf[G_I6];
  assign gz[G_I4] = share_bit(o0, o1, 3'd6);

  for (genvar k = 0; k < N_GADGETS; k++) begin : g_gadget
    isw1_pini_inv_cfn_fr u_gadget (
`ifdef SKINNY_INV_SBOX_CLR_EN
      .clr (clr),
`endif
      .f   (gf[k]),
      .a   (ga[k]),
      .b   (gb[k]),
      .z   (gz[k]),
      .r   (m[2*k +: 2]),
      .clk (clk)
    );
  end

  assign res0 = {gf[G_I7][0], gf[G_I6][0], gf[G_I5][0], gf[G_I4][0],
                 gf[G_I3][0], gf[G_I2][0], gf[G_I1][0], gf[G_I0][0]};
  assign res1 = {gf[G_I7][1], gf[G_I6][1], gf[G_I5][1], gf[G_I4][1],
                 gf[G_I3][1], gf[G_I2][1], gf[G_I1][1], gf[G_I0][1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      bo0   <= 8'h00;
      bo1   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_BUSY;
            cnt   <= 4'd0;
          end
        end
        S_BUSY: begin
          if (cnt == BUSY_LAST) begin
            state <= S_DONE;
            bo0   <= res0;
            bo1   <= res1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            if (clr) begin
              bo0 <= 8'h00;
              bo1 <= 8'h00;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_inv_sbox8_isw1_pini_ctrl.sv
// tb/tb_skinny_inv_sbox8_isw1_pini_ctrl.sv - self-checking bench for the masked SKINNY inverse S-box
// Optional feature macro: SKINNY_INV_SBOX_CLR_EN
module tb_skinny_inv_sbox8_isw1_pini_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  si0, si1, bo0, bo1;
  logic [15:0] r;
  logic        in_valid, in_ready, out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] inv_tbl [256];

  always #5 clk = ~clk;

  skinny_inv_sbox8_isw1_pini_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .si0       (si0),
    .si1       (si1),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bo0       (bo0),
    .bo1       (bo1),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Forward SKINNY-128 S-box from its mix/permute/swap definition
  function automatic logic [7:0] sbox_fwd(input logic [7:0] xin);
    logic [7:0] x;
    x = xin;
    for (int i = 0; i < 4; i++) begin
      x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
      if (i < 3)
        x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
            ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    end
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] o, input logic [7:0] s1, input logic [15:0] rr);
    int n;
    n = 0;
    si0 = o ^ s1;
    si1 = s1;
    r = rr;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    si0 = 8'($urandom);
    si1 = 8'($urandom);
    r = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    logic rdy_low;
    rdy_low = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      si0 = 8'($urandom);
      si1 = 8'($urandom);
      r = 16'($urandom);
      step();
      lat++;
      if (in_ready) rdy_low = 1'b0;
    end
    in_valid = 1'b0;
    chk("in_ready_low_while_busy", 16'(rdy_low), 16'd1);
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_release", 16'(in_ready), 16'd1);
    chk("out_valid_after_release", 16'(out_valid), 16'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] o, first_bo0, save0, save1;
    logic varied, quiet;

    for (int i = 0; i < 256; i++) inv_tbl[sbox_fwd(8'(i))] = 8'(i);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; si0 = 8'h00; si1 = 8'h00; r = 16'h0;
    step(); step(); step();
    chk("reset_in_ready", 16'(in_ready), 16'd0);
    chk("reset_out_valid", 16'(out_valid), 16'd0);
    chk("reset_bo0", 16'(bo0), 16'h00);
    chk("reset_bo1", 16'(bo1), 16'h00);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 16'(in_ready), 16'd1);

    // Accept test with the fixed shares
    start_op(8'h65, 8'hA5, 16'h1234);
    wait_done(lat);
    chk("accept_latency", 16'(lat), 16'd12);
    chk("accept_result", 16'(bo0 ^ bo1), 16'(inv_tbl[8'h65]));
    chk("accept_result_const", 16'(bo0 ^ bo1), 16'h00);
    release_op();

    // Mask independence
    varied = 1'b0;
    first_bo0 = 8'h00;
    for (int i = 0; i < 32; i++) begin
      start_op(8'h4C, 8'($urandom), 16'($urandom));
      wait_done(lat);
      chk("mask_indep_result", 16'(bo0 ^ bo1), 16'h01);
      if (i == 0) first_bo0 = bo0;
      else if (bo0 !== first_bo0) varied = 1'b1;
      release_op();
    end
    chk("mask_indep_bo0_varies", 16'(varied), 16'd1);

    // Backpressure with in_valid asserted throughout
    start_op(8'hFF, 8'($urandom), 16'($urandom));
    wait_done(lat);
    chk("bp_latency", 16'(lat), 16'd12);
    chk("bp_result", 16'(bo0 ^ bo1), 16'(inv_tbl[8'hFF]));
    save0 = bo0;
    save1 = bo1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      si0 = 8'($urandom);
      si1 = 8'($urandom);
      step();
      chk("bp_out_valid", 16'(out_valid), 16'd1);
      chk("bp_in_ready", 16'(in_ready), 16'd0);
      chk("bp_bo0_stable", 16'(bo0), 16'(save0));
      chk("bp_bo1_stable", 16'(bo1), 16'(save1));
    end
    in_valid = 1'b0;
    release_op();
`ifdef SKINNY_INV_SBOX_CLR_EN
    chk("clr_bo0_after_release", 16'(bo0), 16'h00);
    chk("clr_bo1_after_release", 16'(bo1), 16'h00);
`else
    chk("keep_bo0_after_release", 16'(bo0), 16'(save0));
    chk("keep_bo1_after_release", 16'(bo1), 16'(save1));
`endif

    // Reset while busy at count 5
    start_op(8'($urandom), 8'($urandom), 16'($urandom));
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_bo0", 16'(bo0), 16'h00);
    chk("midrst_bo1", 16'(bo1), 16'h00);
    chk("midrst_in_ready", 16'(in_ready), 16'd1);
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) quiet = 1'b0;
    end
    chk("midrst_no_output", 16'(quiet), 16'd1);
    start_op(8'h65, 8'($urandom), 16'($urandom));
    wait_done(lat);
    chk("midrst_next_latency", 16'(lat), 16'd12);
    chk("midrst_next_result", 16'(bo0 ^ bo1), 16'h00);
    release_op();

    // Exhaustive sweep with random masks
    for (int v = 0; v < 256; v++) begin
      o = 8'(v);
      start_op(o, 8'($urandom), 16'($urandom));
      wait_done(lat);
      chk("sweep_latency", 16'(lat), 16'd12);
      chk("sweep_result", 16'(bo0 ^ bo1), 16'(inv_tbl[o]));
      release_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
